// File: rtl/stopwatch_pkg.sv
// Shared constants and width helper for the stopwatch datapath.
package stopwatch_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Divides clk down to one-cycle sub-second ticks. Holds its phase while
// disabled so a stop/start pair resumes the partial period.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2w(TICK_CYC);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYC - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  // Phase counter: cleared by clr, wraps on tick, frozen when not enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pcnt <= '0;
    else if (clr)     pcnt <= '0;
    else if (tick)    pcnt <= '0;
    else if (en)      pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer datapath: seconds + sub-second count with up/down modes,
// preload, lap capture and wrap-or-saturate at full scale.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 500000,
  parameter int SUB_DIV = 10,
  parameter int SEC_MAX = 999,
  parameter int WRAP_EN = 1,
  localparam int TICK_CYC = CLK_HZ / SUB_DIV,
  localparam int SW = clog2w(SEC_MAX + 1),
  localparam int DW = clog2w(SUB_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          mode,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [DW-1:0] load_sub,
  input  logic          lap,
  output logic [SW-1:0] cnt_sec,
  output logic [DW-1:0] cnt_sub,
  output logic          running,
  output logic [SW-1:0] lap_sec,
  output logic [DW-1:0] lap_sub,
  output logic          lap_valid,
  output logic          done,
  output logic          wrapped
);

  typedef struct packed {
    logic [SW-1:0] sec;
    logic [DW-1:0] sub;
  } count_t;

  localparam logic [SW-1:0] SEC_TOP = SW'(SEC_MAX);
  localparam logic [DW-1:0] SUB_TOP = DW'(SUB_DIV - 1);

  count_t cnt;
  count_t lap_q;
  count_t ld_val;
  logic   mode_q;
  logic   tick;
  logic   pre_en;
  logic   is_zero;
  logic   is_top;
  logic   is_one_sub;

  // The prescaler only advances in cycles where the count may take a tick;
  // a stop or clear in the same cycle freezes/clears it instead.
  assign pre_en = running && !stop && !clear;

  tick_prescaler #(.TICK_CYC(TICK_CYC)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (clear),
    .tick  (tick)
  );

  assign is_zero    = (cnt.sec == '0) && (cnt.sub == '0);
  assign is_top     = (cnt.sec == SEC_TOP) && (cnt.sub == SUB_TOP);
  assign is_one_sub = (cnt.sec == '0) && (cnt.sub == DW'(1));

  // Preload values clamped into the representable range.
  always_comb begin
    ld_val.sec = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;
    ld_val.sub = (load_sub > SUB_TOP) ? SUB_TOP : load_sub;
  end

  // Count, run state and mode latch; one control action per cycle in
  // priority clear > load > stop > start > tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      running <= 1'b0;
      mode_q  <= MODE_UP;
      done    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      done    <= 1'b0;
      wrapped <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (load && !running) begin
        cnt <= ld_val;
      end else if (stop) begin
        running <= 1'b0;
      end else if (start && !running) begin
        // A down count from 0.0 has nothing to do.
        if (!(mode == MODE_DOWN && is_zero)) begin
          running <= 1'b1;
          mode_q  <= mode;
        end
      end else if (tick) begin
        if (mode_q == MODE_UP) begin
          if (is_top) begin
            if (WRAP_EN != 0) begin
              cnt     <= '0;
              wrapped <= 1'b1;
            end else begin
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else if (cnt.sub == SUB_TOP) begin
            cnt.sub <= '0;
            cnt.sec <= cnt.sec + 1'b1;
          end else begin
            cnt.sub <= cnt.sub + 1'b1;
          end
        end else begin
          // A clear while running down can leave 0.0 live; stop there.
          if (is_zero) begin
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            if (cnt.sub == '0) begin
              cnt.sub <= SUB_TOP;
              cnt.sec <= cnt.sec - 1'b1;
            end else begin
              cnt.sub <= cnt.sub - 1'b1;
            end
            if (is_one_sub) begin
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Lap capture of the pre-tick count; survives clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q     <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap;
      if (lap) lap_q <= cnt;
    end
  end

  assign cnt_sec = cnt.sec;
  assign cnt_sub = cnt.sub;
  assign lap_sec = lap_q.sec;
  assign lap_sub = lap_q.sub;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench: stimulus pushes expected snapshots/events into queues,
// a negedge monitor pops and compares against two instances (wrap/saturate).
module tb_stopwatch_core;

  localparam int CLK_HZ = 100, SUB_DIV = 10, SEC_MAX = 9;
  localparam int SW = 4, DW = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic start = 0, stop = 0, clear = 0, mode = 0, load = 0, lap = 0;
  logic [SW-1:0] load_sec = '0;
  logic [DW-1:0] load_sub = '0;

  logic [SW-1:0] w_sec, s_sec, w_lsec, s_lsec;
  logic [DW-1:0] w_sub, s_sub, w_lsub, s_lsub;
  logic w_run, s_run, w_lv, s_lv, w_done, s_done, w_wrap, s_wrap;

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_HZ(CLK_HZ), .SUB_DIV(SUB_DIV), .SEC_MAX(SEC_MAX), .WRAP_EN(1)) u_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .mode(mode),
    .load(load), .load_sec(load_sec), .load_sub(load_sub), .lap(lap),
    .cnt_sec(w_sec), .cnt_sub(w_sub), .running(w_run), .lap_sec(w_lsec), .lap_sub(w_lsub),
    .lap_valid(w_lv), .done(w_done), .wrapped(w_wrap));

  stopwatch_core #(.CLK_HZ(CLK_HZ), .SUB_DIV(SUB_DIV), .SEC_MAX(SEC_MAX), .WRAP_EN(0)) u_s (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .mode(mode),
    .load(load), .load_sec(load_sec), .load_sub(load_sub), .lap(lap),
    .cnt_sec(s_sec), .cnt_sub(s_sub), .running(s_run), .lap_sec(s_lsec), .lap_sub(s_lsub),
    .lap_valid(s_lv), .done(s_done), .wrapped(s_wrap));

  typedef struct {
    string nm;
    bit    which;    // 0 = wrap instance, 1 = saturate instance
    int    sec, sub;
    bit    run;
    bit    full;     // also check lap regs and that no pulse is high
    int    lsec, lsub;
  } snap_t;

  typedef struct {
    string nm;
    int    sec, sub;   // count (or lap value) expected when the pulse appears
    int    csec, csub; // count expected alongside a lap pulse
  } ev_t;

  snap_t sq[$];
  ev_t   lapq[$], doneq_w[$], doneq_s[$], wrapq_w[$];
  int    checks = 0, failures = 0;
  bit    final_req = 0, final_done = 0;

  // Monitor: every negedge drain snapshots and match output pulses to events.
  always @(negedge clk) begin
    snap_t e;
    ev_t   v;
    int    a_sec, a_sub, a_lsec, a_lsub, a_pul;
    bit    a_run;
    while (sq.size() > 0) begin
      e = sq.pop_front();
      if (e.which) begin
        a_sec = s_sec; a_sub = s_sub; a_run = s_run; a_lsec = s_lsec; a_lsub = s_lsub;
        a_pul = {s_lv, s_done, s_wrap};
      end else begin
        a_sec = w_sec; a_sub = w_sub; a_run = w_run; a_lsec = w_lsec; a_lsub = w_lsub;
        a_pul = {w_lv, w_done, w_wrap};
      end
      checks++;
      if (a_sec != e.sec || a_sub != e.sub || a_run != e.run ||
          (e.full && (a_lsec != e.lsec || a_lsub != e.lsub || a_pul != 0))) begin
        failures++;
        $display("FAIL %s: got cnt=%0d.%0d run=%0d lap=%0d.%0d pulses=%0d, want cnt=%0d.%0d run=%0d lap=%0d.%0d pulses=0",
                 e.nm, a_sec, a_sub, a_run, a_lsec, a_lsub, a_pul, e.sec, e.sub, e.run, e.lsec, e.lsub);
      end
    end
    if (w_lv) begin
      checks++;
      if (lapq.size() == 0) begin
        failures++; $display("FAIL lap_unexpected: lap_valid high, no lap expected");
      end else begin
        v = lapq.pop_front();
        if (w_lsec != v.sec || w_lsub != v.sub || w_sec != v.csec || w_sub != v.csub) begin
          failures++;
          $display("FAIL %s: got lap=%0d.%0d cnt=%0d.%0d, want lap=%0d.%0d cnt=%0d.%0d",
                   v.nm, w_lsec, w_lsub, w_sec, w_sub, v.sec, v.sub, v.csec, v.csub);
        end
      end
    end
    if (w_done) begin
      checks++;
      if (doneq_w.size() == 0) begin
        failures++; $display("FAIL done_w_unexpected: done high at cnt=%0d.%0d", w_sec, w_sub);
      end else begin
        v = doneq_w.pop_front();
        if (w_sec != v.sec || w_sub != v.sub) begin
          failures++; $display("FAIL %s: got cnt=%0d.%0d at done, want %0d.%0d", v.nm, w_sec, w_sub, v.sec, v.sub);
        end
      end
    end
    if (s_done) begin
      checks++;
      if (doneq_s.size() == 0) begin
        failures++; $display("FAIL done_s_unexpected: done high at cnt=%0d.%0d", s_sec, s_sub);
      end else begin
        v = doneq_s.pop_front();
        if (s_sec != v.sec || s_sub != v.sub) begin
          failures++; $display("FAIL %s: got cnt=%0d.%0d at done, want %0d.%0d", v.nm, s_sec, s_sub, v.sec, v.sub);
        end
      end
    end
    if (w_wrap) begin
      checks++;
      if (wrapq_w.size() == 0) begin
        failures++; $display("FAIL wrap_unexpected: wrapped high at cnt=%0d.%0d", w_sec, w_sub);
      end else begin
        v = wrapq_w.pop_front();
        if (w_sec != v.sec || w_sub != v.sub) begin
          failures++; $display("FAIL %s: got cnt=%0d.%0d at wrap, want %0d.%0d", v.nm, w_sec, w_sub, v.sec, v.sub);
        end
      end
    end
    if (s_wrap) begin
      checks++; failures++;
      $display("FAIL wrap_s_unexpected: saturating instance pulsed wrapped, got 1 want 0");
    end
    if (final_req && !final_done) begin
      final_done = 1;
      checks += 4;
      if (lapq.size() != 0)    begin failures++; $display("FAIL lap_missing: %0d pending, want 0", lapq.size()); end
      if (doneq_w.size() != 0) begin failures++; $display("FAIL done_w_missing: %0d pending, want 0", doneq_w.size()); end
      if (doneq_s.size() != 0) begin failures++; $display("FAIL done_s_missing: %0d pending, want 0", doneq_s.size()); end
      if (wrapq_w.size() != 0) begin failures++; $display("FAIL wrap_missing: %0d pending, want 0", wrapq_w.size()); end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input bit which, input int sec, input int sub, input bit run);
    snap_t e;
    e.nm = nm; e.which = which; e.sec = sec; e.sub = sub; e.run = run;
    e.full = 0; e.lsec = 0; e.lsub = 0;
    sq.push_back(e);
  endtask

  task automatic chk_all(input string nm, input bit which, input int sec, input int sub,
                         input bit run, input int lsec, input int lsub);
    snap_t e;
    e.nm = nm; e.which = which; e.sec = sec; e.sub = sub; e.run = run;
    e.full = 1; e.lsec = lsec; e.lsub = lsub;
    sq.push_back(e);
  endtask

  function automatic ev_t mk_ev(input string nm, input int sec, input int sub, input int csec, input int csub);
    ev_t v;
    v.nm = nm; v.sec = sec; v.sub = sub; v.csec = csec; v.csub = csub;
    return v;
  endfunction

  task automatic do_reset;
    reset = 1'b0; cyc(2); reset = 1'b1; cyc(1);
  endtask

  task automatic p_start; start = 1; cyc(1); start = 0; endtask
  task automatic p_stop;  stop  = 1; cyc(1); stop  = 0; endtask
  task automatic p_clear; clear = 1; cyc(1); clear = 0; endtask
  task automatic p_load(input int s, input int u);
    load_sec = SW'(s); load_sub = DW'(u); load = 1; cyc(1); load = 0;
  endtask

  initial begin
    // 1: run/stop/resume with partial prescaler period; mode change while running ignored
    do_reset;
    chk_all("reset_w", 0, 0, 0, 0, 0, 0);
    chk_all("reset_s", 1, 0, 0, 0, 0, 0);
    mode = 0;
    p_start;
    mode = 1;
    cyc(250);
    chk("run250", 0, 2, 5, 1);
    mode = 0;
    p_stop;
    cyc(50);
    chk("stopped_hold", 0, 2, 5, 0);
    p_start; cyc(5); p_stop;
    chk("partial_hold", 0, 2, 5, 0);
    p_start; cyc(5);
    chk("resume_tick", 0, 2, 6, 1);
    p_stop;

    // 2: clamp, wrap vs saturate at full scale
    do_reset;
    p_load(15, 15);
    chk("load_clamp", 0, 9, 9, 0);
    p_load(9, 8);
    chk("load_98", 1, 9, 8, 0);
    wrapq_w.push_back(mk_ev("wrap_at", 0, 0, 0, 0));
    doneq_s.push_back(mk_ev("sat_done_at", 9, 9, 0, 0));
    p_start; cyc(20);
    chk("wrap_cnt", 0, 0, 0, 1);
    chk("sat_hold", 1, 9, 9, 0);
    p_stop; cyc(3);

    // 3: count down to zero, then start at 0.0 is refused
    do_reset;
    p_load(0, 3);
    mode = 1;
    doneq_w.push_back(mk_ev("down_done_w", 0, 0, 0, 0));
    doneq_s.push_back(mk_ev("down_done_s", 0, 0, 0, 0));
    p_start; cyc(29);
    chk("down_29", 0, 0, 1, 1);
    cyc(1);
    chk("down_30", 0, 0, 0, 0);
    p_start; cyc(15);
    chk("down_restart_ignored", 0, 0, 0, 0);
    mode = 0;

    // 4: lap in the same cycle as a tick captures the pre-tick value
    do_reset;
    p_load(1, 3);
    p_start; cyc(19);
    lapq.push_back(mk_ev("lap_tick", 1, 4, 1, 5));
    lap = 1; cyc(1); lap = 0;
    chk("after_lap", 0, 1, 5, 1);
    p_clear;
    chk_all("clear_keeps_lap", 0, 0, 0, 1, 1, 4);
    p_stop;

    // 5: start+stop together, stop while stopped, load while running, clear while running
    do_reset;
    start = 1; stop = 1; cyc(1); start = 0; stop = 0;
    chk("start_stop_same", 0, 0, 0, 0);
    p_stop;
    chk("stop_while_stopped", 0, 0, 0, 0);
    p_load(3, 7);
    chk("load_37", 0, 3, 7, 0);
    p_start;
    p_load(5, 5);
    chk("load_running_ignored", 0, 3, 7, 1);
    cyc(3);
    p_clear;
    chk("clear_running", 0, 0, 0, 1);
    cyc(4); p_start; cyc(4);
    chk("clear_no_early_tick", 0, 0, 0, 1);
    cyc(1);
    chk("clear_first_tick", 0, 0, 1, 1);
    p_stop;

    // 6: asynchronous reset mid-period
    do_reset;
    p_load(4, 2);
    p_start; cyc(5);
    #1 reset = 1'b0;
    chk_all("async_reset_w", 0, 0, 0, 0, 0, 0);
    chk_all("async_reset_s", 1, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    reset = 1'b1;
    cyc(3);

    final_req = 1;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
